// File: rtl/spi_pkg.sv
// Shared definitions for the 10-bit-frame SPI master: command encodings,
// frame and read widths, and the master FSM state encoding.
package spi_pkg;

  localparam int FRAME_W = 10;
  localparam int RD_W    = 8;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } spi_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_CMD,
    ST_SEND,
    ST_TAIL,
    ST_WAIT,
    ST_RECV,
    ST_DESELECT
  } spi_state_e;

endpackage

// File: rtl/spi_master_shifter.sv
// Datapath for spi_master: 10-bit parallel-load MSB-first shift-out and
// 8-bit MSB-first shift-in with a capture register for the returned byte.
module spi_master_shifter
  import spi_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [FRAME_W-1:0] word_i,
  input  logic               rearm_rd_i,
  input  logic               shift_i,
  output logic               msb_o,
  input  logic               sample_i,
  input  logic               miso_i,
  input  logic               capture_i,
  output logic [RD_W-1:0]    rsp_data_o
);

  logic [FRAME_W-1:0] tx_q;
  logic [RD_W-1:0]    rx_q;
  logic [RD_W-1:0]    rsp_q;

  // NOTE: tx_q and rx_q are always loaded or fully shifted before they are
  // observed, so only the externally visible rsp_q carries a reset.
  always_ff @(posedge clk) begin
    if (load_i) begin
      tx_q <= word_i;
    end else if (rearm_rd_i) begin
      tx_q <= {CMD_RD_DATA, tx_q[RD_W-1:0]};
    end else if (shift_i) begin
      // Rotate rather than shift: after a full frame the word is intact again.
      tx_q <= {tx_q[FRAME_W-2:0], tx_q[FRAME_W-1]};
    end
    if (sample_i) begin
      rx_q <= {rx_q[RD_W-2:0], miso_i};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_q <= '0;
    end else if (capture_i) begin
      rsp_q <= rx_q;
    end
  end

  assign msb_o      = tx_q[FRAME_W-1];
  assign rsp_data_o = rsp_q;

endmodule

// File: rtl/spi_master.sv
// Single-clock SPI master for the 10-bit-frame slave protocol (slave shares clk).
// Define SPI_MASTER_AUTO_RD_EN to chain a read-data frame after each read-address frame.
module spi_master
  import spi_pkg::*;
#(
  parameter int TAIL       = 2,
  parameter int RD_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [1:0] req_cmd_i,
  input  logic [7:0] req_data_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic       ss_n_o,
  output logic       mosi_o,
  input  logic       miso_i
);

  localparam logic [7:0] TAIL_LAST = 8'(TAIL - 1);
  localparam logic [7:0] WAIT_LAST = 8'(RD_LATENCY - 1);

  spi_state_e state_q;
  spi_cmd_e   cmd_q;
  logic [3:0] bit_cnt_q;
  logic [7:0] cnt_q;
  logic       ss_n_q;
  logic       mosi_q;
  logic       ready_q;
  logic       rsp_valid_q;

  logic accept;
  logic auto_rd;
  logic tx_msb;

  assign accept = (state_q == ST_IDLE) && ready_q && req_valid_i;

`ifdef SPI_MASTER_AUTO_RD_EN
  assign auto_rd = (state_q == ST_DESELECT) && (cmd_q == CMD_RD_ADDR);
`else
  assign auto_rd = 1'b0;
`endif

  spi_master_shifter u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept),
    .word_i     ({req_cmd_i, req_data_i}),
    .rearm_rd_i (auto_rd),
    .shift_i    (state_q == ST_SEND),
    .msb_o      (tx_msb),
    .sample_i   (state_q == ST_RECV),
    .miso_i     (miso_i),
    .capture_i  ((state_q == ST_DESELECT) && (cmd_q == CMD_RD_DATA)),
    .rsp_data_o (rsp_data_o)
  );

  // NOTE: every register here uses non-blocking assignment so all state
  // updates on an edge see the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= CMD_WR_ADDR;
      bit_cnt_q   <= '0;
      cnt_q       <= '0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          ss_n_q <= 1'b1;
          mosi_q <= 1'b0;
          if (accept) begin
            ready_q <= 1'b0;
            cmd_q   <= spi_cmd_e'(req_cmd_i);
            state_q <= ST_SELECT;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_SELECT: begin
          ss_n_q  <= 1'b0;
          mosi_q  <= 1'b0;
          state_q <= ST_CMD;
        end
        ST_CMD: begin
          mosi_q    <= tx_msb;
          bit_cnt_q <= '0;
          state_q   <= ST_SEND;
        end
        ST_SEND: begin
          mosi_q    <= tx_msb;
          bit_cnt_q <= bit_cnt_q + 4'd1;
          cnt_q     <= '0;
          if (bit_cnt_q == 4'(FRAME_W - 1)) begin
            if (cmd_q != CMD_RD_DATA) begin
              state_q <= ST_TAIL;
            end else if (RD_LATENCY == 0) begin
              bit_cnt_q <= '0;
              state_q   <= ST_RECV;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_TAIL: begin
          mosi_q <= 1'b0;
          cnt_q  <= cnt_q + 8'd1;
          if (cnt_q == TAIL_LAST) state_q <= ST_DESELECT;
        end
        ST_WAIT: begin
          mosi_q <= 1'b0;
          cnt_q  <= cnt_q + 8'd1;
          if (cnt_q == WAIT_LAST) begin
            bit_cnt_q <= '0;
            state_q   <= ST_RECV;
          end
        end
        ST_RECV: begin
          mosi_q    <= 1'b0;
          bit_cnt_q <= bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(RD_W - 1)) state_q <= ST_DESELECT;
        end
        ST_DESELECT: begin
          ss_n_q      <= 1'b1;
          mosi_q      <= 1'b0;
          rsp_valid_q <= (cmd_q == CMD_RD_DATA);
          // ready_q stays low through a chained frame; IDLE raises it a cycle later.
          if (auto_rd) begin
            cmd_q   <= CMD_RD_DATA;
            state_q <= ST_SELECT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign ss_n_o      = ss_n_q;
  assign mosi_o      = mosi_q;

endmodule
